mesh_term_bridge: RTL
=====================

Name: mesh_term_bridge

Overview:
- Parametrised terminal-side bridge between the verification environment and mesh_gnrtr.
- Ingress path: one buffered FIFO per mesh terminal, so the bench can queue packets without tracking mesh popin timing.
- Egress path: drains every terminal's pndng/data_out with round-robin arbitration into a single collector stream tagged with the source terminal.
- Sits between dut_if and the mesh in the next-generation wrapper.

Parameters:
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- PCKG_SZ, 40, packet width in bits.
- FIFO_DEPTH, 4, ingress FIFO entries per terminal (≥2).
- NTERM, 2*(ROWS+COLUMS), terminal count; derived, not overridable.
- TW, $clog2(NTERM), terminal index width; derived.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- tb_push  in  NTERM  bench write strobe, one per terminal.
- tb_data  in  NTERM*PCKG_SZ  bench write data; terminal i occupies bits [i*PCKG_SZ +: PCKG_SZ].
- tb_full  out  NTERM  ingress FIFO i holds FIFO_DEPTH entries.
- pndng_i_in  out  NTERM  to mesh: ingress FIFO i is non-empty.
- data_out_i_in  out  NTERM*PCKG_SZ  to mesh: head entry of each ingress FIFO.
- popin  in  NTERM  from mesh: consume the head of ingress FIFO i.
- pndng  in  NTERM  from mesh: terminal i has an output packet.
- data_out  in  NTERM*PCKG_SZ  from mesh: output packet of each terminal.
- pop  out  NTERM  to mesh: one-hot consume strobe.
- col_valid  out  1  collector holds a packet.
- col_data  out  PCKG_SZ  collected packet.
- col_term  out  TW  source terminal of col_data.
- col_ready  in  1  bench accepts the collector packet.

Behaviour:
- Reset: reset==0 at a rising clk edge clears all state. While held and after release, every output is 0: pndng_i_in, data_out_i_in, pop, col_valid, col_data, col_term, tb_full. The RR pointer is also 0. Reset asserted mid-transfer discards all queued and held packets with no pop emitted.
- Ingress FIFO i: circular buffer with count 0..FIFO_DEPTH.
  - Push: tb_push[i] with count<FIFO_DEPTH writes tb_data slice i.
  - Full: tb_full[i]=(count==FIFO_DEPTH), combinational from registered count. A push while full is dropped, even if popin[i] is asserted the same cycle.
  - Pop: popin[i] with count>0 advances the head. popin[i] while empty is ignored.
  - Push and pop in the same cycle with 0<count<FIFO_DEPTH: count unchanged, both take effect.
  - No fall-through: a push into an empty FIFO raises pndng_i_in[i] the next cycle.
  - Wrap: read and write pointers wrap modulo FIFO_DEPTH, including non-power-of-2 depths.
- Egress collector FSM, states EMPTY and HOLD:
  - Grant condition: in EMPTY, or in HOLD with col_ready=1, pick the first terminal j with pndng[j]=1, searching from rr_ptr upward with modulo-NTERM wrap.
  - On a grant: assert pop[j]=1 combinationally that cycle. At the next edge load col_data=data_out slice j and col_term=j, set col_valid=1 (state HOLD), and set rr_ptr=(j+1) mod NTERM.
  - HOLD with col_ready=0: no pop; col_data and col_term stay stable.
  - HOLD with col_ready=1 and no pndng: go to EMPTY, col_valid=0. col_data and col_term keep their last value.
  - HOLD with col_ready=1 and a new grant: back-to-back transfer, col_valid stays 1 and new data loads.
  - Latency: pop at cycle t, col_valid/data at t+1. Sustained throughput is 1 packet/cycle when col_ready=1.
  - pop is at most one-hot and never asserted for a terminal with pndng=0.
  - The RR pointer changes only on a grant. All NTERM terminals pending continuously are served in index order, each within NTERM grants.

Optional Feature:
- Macro: MESH_TERM_BRIDGE_STATS_EN.
- Defined: adds output ports drop_cnt [16*NTERM] and col_cnt [32].
  - drop_cnt slice i counts pushes dropped while tb_full[i]=1, saturating at 16'hFFFF.
  - col_cnt counts accepted collector transfers (col_valid & col_ready), wrapping at 2^32.
  - Both counters clear on reset.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset: drive reset=0 for 3 cycles with tb_push and pndng all 1 -> all outputs 0 and pop=0 throughout; pndng_i_in[0]=1 one cycle after the first push following release.
- Fill and drop: defaults, push 5 packets 0xA0..0xA4 to terminal 3 with popin=0 -> tb_full[3]=1 after the 4th push; 0xA4 dropped; drop_cnt[3]=1 if stats enabled. Then pulse popin[3] 4 times -> heads 0xA0..0xA3, then pndng_i_in[3]=0.
- Simultaneous push/pop: terminal 0 count=2, push 0xB0 and popin together -> count stays 2 and the head advances.
- Round-robin fairness: pndng held 1 on terminals 2, 5, 15 with col_ready=1 -> col_term sequence 2, 5, 15, 2, 5…; one pop per cycle; col_valid continuous.
- Backpressure: col_ready=0 for 4 cycles while holding terminal 7's packet 0xCAFE -> pop=0, col_data=0xCAFE and col_term=7 stable; on release the next packet appears the following cycle.
- Wrap: FIFO_DEPTH=3, 10 interleaved push/pop on terminal 1 -> data order preserved across pointer wrap and count never exceeds 3.

Source files
------------

// File: rtl/mesh_term_bridge.sv
// Terminal-side bridge for mesh_gnrtr: one ingress FIFO per terminal and a round-robin egress collector.
// Optional statistics ports and counters are built when MESH_TERM_BRIDGE_STATS_EN is defined.
module mesh_term_bridge #(
    parameter int  ROWS       = 4,
    parameter int  COLUMS     = 4,
    parameter int  PCKG_SZ    = 40,
    parameter int  FIFO_DEPTH = 4,
    localparam int NTERM      = 2 * (ROWS + COLUMS),
    localparam int TW         = $clog2(NTERM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NTERM-1:0]         tb_push,
    input  logic [NTERM*PCKG_SZ-1:0] tb_data,
    output logic [NTERM-1:0]         tb_full,
    output logic [NTERM-1:0]         pndng_i_in,
    output logic [NTERM*PCKG_SZ-1:0] data_out_i_in,
    input  logic [NTERM-1:0]         popin,
    input  logic [NTERM-1:0]         pndng,
    input  logic [NTERM*PCKG_SZ-1:0] data_out,
    output logic [NTERM-1:0]         pop,
    output logic                     col_valid,
    output logic [PCKG_SZ-1:0]       col_data,
    output logic [TW-1:0]            col_term,
    input  logic                     col_ready
`ifdef MESH_TERM_BRIDGE_STATS_EN
    ,
    output logic [16*NTERM-1:0]      drop_cnt,
    output logic [31:0]              col_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    for (genvar i = 0; i < NTERM; i++) begin : g_ingress
        logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]      wr_ptr;
        logic [PW-1:0]      rd_ptr;
        logic [CW-1:0]      count;
        logic               do_push;
        logic               do_pop;

        assign tb_full[i]    = (count == CNT_FULL);
        assign pndng_i_in[i] = (count != '0);
        // A push while full is dropped even when the head is popped in the same cycle.
        assign do_push       = tb_push[i] && !tb_full[i];
        assign do_pop        = popin[i] && pndng_i_in[i];
        assign data_out_i_in[i*PCKG_SZ +: PCKG_SZ] = pndng_i_in[i] ? mem[rd_ptr] : '0;

        // NOTE: registered state uses non-blocking assignments so every reader sees pre-edge values.
        always_ff @(posedge clk) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end

        // NOTE: storage has no reset; count masks the head, so stale words never reach the mesh.
        always_ff @(posedge clk) begin
            if (do_push) mem[wr_ptr] <= tb_data[i*PCKG_SZ +: PCKG_SZ];
        end
    end

    typedef enum logic {ST_EMPTY, ST_HOLD} col_state_t;

    col_state_t         state;
    col_state_t         state_nxt;
    logic [TW-1:0]      rr_ptr;
    logic [TW-1:0]      grant_idx;
    logic               grant_vld;
    logic               grant;
    logic [TW:0]        cand;
    logic [PCKG_SZ-1:0] egress_word [NTERM];

    for (genvar j = 0; j < NTERM; j++) begin : g_egress_word
        assign egress_word[j] = data_out[j*PCKG_SZ +: PCKG_SZ];
    end

    // First pending terminal at or after rr_ptr, wrapping modulo NTERM.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NTERM; k++) begin
            cand = {1'b0, rr_ptr} + (TW+1)'(k);
            if (cand >= (TW+1)'(NTERM)) cand = cand - (TW+1)'(NTERM);
            if (!grant_vld && pndng[cand[TW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[TW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pop       = '0;
        if (reset && (state == ST_EMPTY || col_ready)) begin
            if (grant_vld) begin
                grant          = 1'b1;
                pop[grant_idx] = 1'b1;
                state_nxt      = ST_HOLD;
            end else begin
                state_nxt = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_EMPTY;
            rr_ptr   <= '0;
            col_data <= '0;
            col_term <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                col_data <= egress_word[grant_idx];
                col_term <= grant_idx;
                rr_ptr   <= (grant_idx == TW'(NTERM - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign col_valid = (state == ST_HOLD);

`ifdef MESH_TERM_BRIDGE_STATS_EN
    for (genvar i = 0; i < NTERM; i++) begin : g_drop
        logic [15:0] cnt;

        assign drop_cnt[i*16 +: 16] = cnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt <= '0;
            end else if (tb_push[i] && tb_full[i] && cnt != 16'hFFFF) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_cnt <= '0;
        end else if (col_valid && col_ready) begin
            col_cnt <= col_cnt + 1'b1;
        end
    end
`endif
endmodule
